// File: rtl/sysid_regs_ext_if.sv
// Avalon-MM slave bus bundle for the system-ID peripheral.
// The master drives address/strobes/write data; the slave returns read data.
interface sysid_regs_ext_if #(
  parameter int ADDR_W = 4
);
  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic [31:0]       writedata;
  logic [3:0]        byteenable;
  logic [31:0]       readdata;
  logic              readdatavalid;

  modport master (
    output address, read, write, writedata, byteenable,
    input  readdata, readdatavalid
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output readdata, readdatavalid
  );
endinterface

// File: rtl/sysid_regs_ext.sv
// System-ID peripheral: fixed ID/timestamp/version words, scratch register,
// 64-bit uptime counter with hi/lo snapshot, live user-status words and a
// fixed-latency read return path.
module sysid_regs_ext #(
  parameter logic [31:0] SYSID        = 32'hACD51302,
  parameter logic [31:0] TIMESTAMP    = 32'h53104B65,
  parameter logic [31:0] VERSION      = 32'h00010000,
  parameter logic [31:0] SCRATCH_INIT = 32'h00000000,
  parameter int          NUM_USER     = 4,
  parameter int          ADDR_W       = 4,
  parameter int          READ_LATENCY = 1
) (
  input  logic                                         clock,
  input  logic                                         reset_n,
  sysid_regs_ext_if.slave                              bus,
  input  logic [32*((NUM_USER > 0) ? NUM_USER : 1)-1:0] user_data
);

  localparam logic [31:0] CAPS = {16'h0, 8'(NUM_USER), 4'h0, 4'(READ_LATENCY)};

  if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
    $fatal(1, "sysid_regs_ext: READ_LATENCY must be within 1..4");
  end
  if (NUM_USER < 0 || NUM_USER > (1 << ADDR_W) - 8) begin : g_bad_num_user
    $fatal(1, "sysid_regs_ext: NUM_USER does not fit in the address space");
  end

  // Merge write data into a register honouring the byte-lane enables.
  function automatic logic [31:0] merge_lanes(input logic [31:0] cur,
                                              input logic [31:0] wd,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = cur;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) res[8*b +: 8] = wd[8*b +: 8];
    end
    return res;
  endfunction

  logic [31:0] scratch;
  logic        en;
  logic [63:0] uptime;
  logic [31:0] uptime_hi_shadow;
  logic [31:0] addr_ext;
  logic [31:0] rd_sel;
  logic        ctrl_wr;
  logic        clr;

  logic [31:0] rd_data_p [READ_LATENCY];
  logic        vld_p     [READ_LATENCY];

  assign addr_ext = 32'(bus.address);
  assign ctrl_wr  = bus.write && (addr_ext == 32'd7);
  assign clr      = ctrl_wr && bus.writedata[1];

  // Read mux: selects the addressed word from the state of the current cycle.
  always_comb begin
    rd_sel = '0;
    case (addr_ext)
      32'd0:   rd_sel = SYSID;
      32'd1:   rd_sel = TIMESTAMP;
      32'd2:   rd_sel = VERSION;
      32'd3:   rd_sel = scratch;
      32'd4:   rd_sel = uptime[31:0];
      32'd5:   rd_sel = uptime_hi_shadow;
      32'd6:   rd_sel = CAPS;
      32'd7:   rd_sel = {31'h0, en};
      default: begin
        for (int k = 0; k < NUM_USER; k++) begin
          if (addr_ext == 32'(k + 8)) rd_sel = user_data[32*k +: 32];
        end
      end
    endcase
  end

  // Scratch and CTRL.en: byte-lane writes to the scratch word, en from CTRL bit 0.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      scratch <= SCRATCH_INIT;
      en      <= 1'b1;
    end else begin
      if (bus.write && addr_ext == 32'd3)
        scratch <= merge_lanes(scratch, bus.writedata, bus.byteenable);
      if (ctrl_wr)
        en <= bus.writedata[0];
    end
  end

  // Uptime counter: clear wins over increment; increment gated by current en.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)  uptime <= '0;
    else if (clr)  uptime <= '0;
    else if (en)   uptime <= uptime + 64'd1;
  end

  // High-word shadow: captured by a read of the low word, untouched by clear.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      uptime_hi_shadow <= '0;
    else if (bus.read && addr_ext == 32'd4)
      uptime_hi_shadow <= uptime[63:32];
  end

  // Read return pipeline: data moves only with its valid, so the last stage
  // holds the most recent returned word between reads.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        rd_data_p[i] <= '0;
        vld_p[i]     <= 1'b0;
      end
    end else begin
      // stage 0: capture the selected word in the read cycle
      vld_p[0] <= bus.read;
      if (bus.read) rd_data_p[0] <= rd_sel;
      // stages 1..READ_LATENCY-1: delay line toward the bus
      for (int i = 1; i < READ_LATENCY; i++) begin
        vld_p[i] <= vld_p[i-1];
        if (vld_p[i-1]) rd_data_p[i] <= rd_data_p[i-1];
      end
    end
  end

  assign bus.readdata      = rd_data_p[READ_LATENCY-1];
  assign bus.readdatavalid = vld_p[READ_LATENCY-1];

endmodule

// File: tb/tb_sysid_regs_ext.sv
// Bench for sysid_regs_ext: two instances (read latency 1 and 3) share one
// stimulus stream; a reference model predicts each read and a monitor
// compares returned words and their arrival cycle.
module tb_sysid_regs_ext;

  localparam int NU = 4;
  localparam int AW = 4;
  localparam logic [31:0] SYSID_C = 32'hACD51302;
  localparam logic [31:0] TS_C    = 32'h53104B65;
  localparam logic [31:0] VER_C   = 32'h00010000;
  localparam logic [31:0] SCR0_C  = 32'h00000000;

  typedef struct {
    logic [31:0] data;
    int          due;
    int          addr;
  } exp_t;

  logic              clock   = 1'b0;
  logic              reset_n = 1'b1;
  logic [32*NU-1:0]  user_data = '0;
  int                cyc = 0;
  int                errors = 0;
  int                checks = 0;
  exp_t              q [2][$];
  logic [31:0]       last_d [2];
  logic              rand_user = 1'b0;

  // reference model state
  logic [31:0] m_scratch;
  logic        m_en;
  logic [63:0] m_up;
  logic [31:0] m_shadow;

  sysid_regs_ext_if #(.ADDR_W(AW)) bus1 ();
  sysid_regs_ext_if #(.ADDR_W(AW)) bus3 ();

  assign bus3.address    = bus1.address;
  assign bus3.read       = bus1.read;
  assign bus3.write      = bus1.write;
  assign bus3.writedata  = bus1.writedata;
  assign bus3.byteenable = bus1.byteenable;

  sysid_regs_ext #(.NUM_USER(NU), .ADDR_W(AW), .READ_LATENCY(1)) dut1 (
    .clock     (clock),
    .reset_n   (reset_n),
    .bus       (bus1),
    .user_data (user_data)
  );

  sysid_regs_ext #(.NUM_USER(NU), .ADDR_W(AW), .READ_LATENCY(3)) dut3 (
    .clock     (clock),
    .reset_n   (reset_n),
    .bus       (bus3),
    .user_data (user_data)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [31:0] model_read(input int a, input int lat);
    case (a)
      0: return SYSID_C;
      1: return TS_C;
      2: return VER_C;
      3: return m_scratch;
      4: return m_up[31:0];
      5: return m_shadow;
      6: return (lat == 1) ? 32'h00000401 : 32'h00000403;
      7: return {31'h0, m_en};
      default: begin
        if (a >= 8 && a < 8 + NU) return user_data[32*(a-8) +: 32];
        return 32'h0;
      end
    endcase
  endfunction

  task automatic model_init();
    m_scratch = SCR0_C;
    m_en      = 1'b1;
    m_up      = '0;
    m_shadow  = '0;
  endtask

  // Drive one bus cycle (already at the drive point) and advance the model
  // to the state after the coming clock edge.
  task automatic drive_apply(input logic rd, input logic wr, input int a,
                             input logic [31:0] wd, input logic [3:0] be);
    logic [63:0] nxt;
    exp_t e;
    bus1.read       = rd;
    bus1.write      = wr;
    bus1.address    = a[AW-1:0];
    bus1.writedata  = wd;
    bus1.byteenable = be;
    if (rd) begin
      e.addr = a;
      e.data = model_read(a, 1); e.due = cyc + 1; q[0].push_back(e);
      e.data = model_read(a, 3); e.due = cyc + 3; q[1].push_back(e);
    end
    if (rd && a == 4) m_shadow = m_up[63:32];
    if (wr && a == 3)
      for (int b = 0; b < 4; b++)
        if (be[b]) m_scratch[8*b +: 8] = wd[8*b +: 8];
    nxt = m_en ? m_up + 64'd1 : m_up;
    if (wr && a == 7) begin
      if (wd[1]) nxt = '0;
      m_en = wd[0];
    end
    m_up = nxt;
  endtask

  task automatic step(input logic rd, input logic wr, input int a,
                      input logic [31:0] wd, input logic [3:0] be);
    @(negedge clock);
    if (rand_user) user_data = {$urandom, $urandom, $urandom, $urandom};
    drive_apply(rd, wr, a, wd, be);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 32'h0, 4'h0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    #1;
    reset_n = 1'b0;
    bus1.read = 1'b0; bus1.write = 1'b0; bus1.address = '0;
    bus1.writedata = '0; bus1.byteenable = '0;
    q[0].delete();
    q[1].delete();
    model_init();
    repeat (2) @(negedge clock);
    @(negedge clock);
    #1;
    reset_n = 1'b1;
    drive_apply(1'b0, 1'b0, 0, 32'h0, 4'h0);
  endtask

  task automatic preload(input logic [63:0] v);
    @(negedge clock);
    force dut1.uptime = v;
    force dut3.uptime = v;
    #1;
    release dut1.uptime;
    release dut3.uptime;
    m_up = v;
    drive_apply(1'b0, 1'b0, 0, 32'h0, 4'h0);
  endtask

  // Monitor: compare every returned word with the oldest expectation.
  always @(negedge clock) begin
    for (int k = 0; k < 2; k++) begin
      logic        v;
      logic [31:0] d;
      exp_t        e;
      v = (k == 0) ? bus1.readdatavalid : bus3.readdatavalid;
      d = (k == 0) ? bus1.readdata      : bus3.readdata;
      if (!reset_n) begin
        checks++;
        if (v || d != 32'h0) begin
          errors++;
          $display("FAIL reset_out lat%0d: valid=%0b data=%h, required valid=0 data=00000000",
                   (k == 0) ? 1 : 3, v, d);
        end
        last_d[k] = 32'h0;
      end else if (v) begin
        checks++;
        if (q[k].size() == 0) begin
          errors++;
          $display("FAIL unexpected_valid lat%0d: data=%h at cycle %0d, required no valid",
                   (k == 0) ? 1 : 3, d, cyc);
        end else begin
          e = q[k].pop_front();
          if (d != e.data || cyc != e.due) begin
            errors++;
            $display("FAIL read_addr%0d lat%0d: got %h at cycle %0d, required %h at cycle %0d",
                     e.addr, (k == 0) ? 1 : 3, d, cyc, e.data, e.due);
          end
        end
        last_d[k] = d;
      end else begin
        checks++;
        if (d != last_d[k]) begin
          errors++;
          $display("FAIL hold lat%0d: readdata=%h while idle, required %h",
                   (k == 0) ? 1 : 3, d, last_d[k]);
        end
        if (q[k].size() > 0 && q[k][0].due <= cyc) begin
          e = q[k].pop_front();
          checks++;
          errors++;
          $display("FAIL missing_valid addr%0d lat%0d: no valid at cycle %0d, required %h",
                   e.addr, (k == 0) ? 1 : 3, cyc, e.data);
        end
      end
    end
  end

  initial begin
    logic        rd;
    logic        wr;
    int          a;
    logic [31:0] wd;
    bus1.read = 1'b0; bus1.write = 1'b0; bus1.address = '0;
    bus1.writedata = '0; bus1.byteenable = '0;
    last_d[0] = '0;
    last_d[1] = '0;
    model_init();
    #1 reset_n = 1'b0;
    do_reset();

    // identification words back to back
    step(1, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0);
    step(1, 0, 6, 0, 0);
    idle(2);

    // scratch byte lanes, and read coinciding with write returns old value
    step(0, 1, 3, 32'hFFFFFFFF, 4'b0101);
    step(1, 0, 3, 0, 0);
    step(1, 1, 3, 32'hA5A51234, 4'hF);
    step(1, 0, 3, 0, 0);

    // clear with en=0 holds counter at zero
    step(0, 1, 7, 32'h2, 4'hF);
    step(1, 0, 4, 0, 0);
    step(1, 0, 4, 0, 0);
    step(1, 0, 5, 0, 0);
    step(1, 0, 7, 0, 0);
    step(0, 1, 7, 32'h1, 4'hF);
    idle(5);
    step(1, 0, 4, 0, 0);
    step(1, 0, 7, 0, 0);

    // snapshot across the 32-bit carry
    preload(64'h00000000_FFFFFFFE);
    step(1, 0, 4, 0, 0);
    step(1, 0, 5, 0, 0);
    step(1, 0, 4, 0, 0);
    step(1, 0, 5, 0, 0);
    // clear does not disturb the shadow
    step(0, 1, 7, 32'h3, 4'hF);
    step(1, 0, 5, 0, 0);
    step(1, 0, 4, 0, 0);

    // user words and an unmapped address on consecutive cycles
    user_data = {32'hCAFEF00D, 32'h12345678, 32'h0BADBEEF, 32'h11111111};
    step(1, 0, 10, 0, 0);
    step(1, 0, 9, 0, 0);
    step(1, 0, 15, 0, 0);
    step(1, 0, 11, 0, 0);
    step(1, 0, 8, 0, 0);
    idle(4);

    // counter frozen while disabled
    step(0, 1, 7, 32'h0, 4'hF);
    idle(100);
    step(1, 0, 4, 0, 0);
    step(1, 0, 4, 0, 0);
    step(0, 1, 7, 32'h1, 4'hF);

    // randomized traffic
    rand_user = 1'b1;
    for (int i = 0; i < 400; i++) begin
      rd = 1'($urandom % 2);
      wr = ($urandom % 3) == 0;
      a  = int'($urandom % 16);
      wd = $urandom;
      if (a == 7) wd[0] = ($urandom % 4) != 0;
      step(rd, wr, a, wd, 4'($urandom % 16));
    end
    rand_user = 1'b0;
    idle(4);

    // reset one cycle after a read discards it and restores scratch
    step(0, 1, 3, 32'hDEADBEEF, 4'hF);
    step(1, 0, 3, 0, 0);
    idle(1);
    do_reset();
    step(1, 0, 3, 0, 0);
    step(1, 0, 7, 0, 0);
    step(1, 0, 5, 0, 0);
    idle(6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
